// File: rtl/jump_resolve_unit.sv
// -----------------------------------------------------------------------------
// jump_resolve_unit
//
// This unit resolves jump targets in the ID stage of the pipelined MIPS core.
// It handles three instructions:
//   j   : pseudo-direct target built from the upper bits of PC+4 and the
//         26-bit immediate.
//   jal : same target as j, and also writes a link value to $31.
//   jr  : target is the value of rs. If a later pipeline stage is about to
//         write rs, the value is forwarded from EX/MEM or MEM/WB.
//
// When a jr operand is not ready yet, the unit stalls. The cases are:
//   - the producer is still in ID/EX, or
//   - the producer is a load sitting in EX/MEM.
// While stalled, a small FSM sits in WAIT. The frozen IF/ID register keeps the
// ID inputs stable, and the hazard is re-checked every cycle.
//
// Each resolved jump produces a registered one-cycle redirect pulse to IF,
// together with its target. A jal also produces a link-write pulse in the
// same cycle.
//
// Parameters
//   XLEN       datapath / address width
//   REGW       register index width
//   IMMW       jump immediate width (XLEN >= IMMW+3)
//   DELAY_SLOT 1: architectural delay slot, IF is never squashed
//              0: flush_if follows redirect, and the ID instruction in the
//                 redirect cycle is ignored
//
// Ports
//   clk, rst_n             core clock, asynchronous active-low reset
//   flush                  squash from a later stage; cancels pending work
//   id_valid               ID holds a valid instruction
//   id_j, id_jal, id_jr    decoded jump type (priority jr > jal > j)
//   id_rs, id_rs_val       rs index and register-file value
//   id_imm, id_pc4         jump immediate and PC+4 of the ID instruction
//   idex_*                 ID/EX destination / write enable
//   exmem_*                EX/MEM destination / write enable / load / result
//   memwb_*                MEM/WB destination / write enable / value
//   stall                  freeze PC and IF/ID (combinational)
//   redirect, redirect_addr  registered redirect pulse and target
//   flush_if               registered IF squash (DELAY_SLOT=0 only)
//   link_we, link_addr     registered link write pulse and return address
//   misalign               registered pulse: jr target not word aligned
// -----------------------------------------------------------------------------
module jump_resolve_unit #(
  parameter int XLEN       = 32,
  parameter int REGW       = 5,
  parameter int IMMW       = 26,
  parameter int DELAY_SLOT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  input  logic            id_j,
  input  logic            id_jal,
  input  logic            id_jr,
  input  logic [REGW-1:0] id_rs,
  input  logic [XLEN-1:0] id_rs_val,
  input  logic [IMMW-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc4,
  input  logic [REGW-1:0] idex_dst,
  input  logic            idex_wen,
  input  logic [REGW-1:0] exmem_dst,
  input  logic            exmem_wen,
  input  logic            exmem_load,
  input  logic [XLEN-1:0] exmem_val,
  input  logic [REGW-1:0] memwb_dst,
  input  logic            memwb_wen,
  input  logic [XLEN-1:0] memwb_val,
  output logic            stall,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_addr,
  output logic            flush_if,
  output logic            link_we,
  output logic [XLEN-1:0] link_addr,
  output logic            misalign
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // With a delay slot, the link skips the slot instruction.
  localparam logic [XLEN-1:0] LINK_OFS = (DELAY_SLOT != 0) ? XLEN'(4) : '0;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic            redirect_q, redirect_d;
  logic            flush_if_q, flush_if_d;
  logic            link_we_q, link_we_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] redirect_addr_q, redirect_addr_d;
  logic [XLEN-1:0] link_addr_q, link_addr_d;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  // Without a delay slot, the instruction in ID during the redirect cycle is
  // the wrong-path fetch and is being flushed, so it must not be resolved.
  logic squash_win;
  logic id_live;
  logic dec_jr, dec_jal, dec_j;

  assign squash_win = (DELAY_SLOT == 0) && redirect_q;
  assign id_live    = id_valid && !squash_win;
  assign dec_jr     = id_live && id_jr;
  assign dec_jal    = id_live && !id_jr && id_jal;
  assign dec_j      = id_live && !id_jr && !id_jal && id_j;

  // Pseudo-direct target: the region bits of PC+4, then the immediate,
  // then a word offset of zero.
  logic [XLEN-1:0] jmp_target;
  assign jmp_target = {id_pc4[XLEN-1:IMMW+2], id_imm, 2'b00};

  // ---------------------------------------------------------------------------
  // jr operand selection
  // ---------------------------------------------------------------------------
  // rs == 0 is checked first. Every later match therefore implies dst != 0,
  // which is how a write to $0 is kept from ever forwarding or stalling.
  logic            rs_is_zero;
  logic            hit_idex, hit_exmem, hit_memwb;
  logic            jr_hazard;
  logic [XLEN-1:0] jr_value;
  logic            jr_misaligned;

  assign rs_is_zero = (id_rs == '0);
  assign hit_idex   = idex_wen  && (idex_dst  == id_rs);
  assign hit_exmem  = exmem_wen && (exmem_dst == id_rs);
  assign hit_memwb  = memwb_wen && (memwb_dst == id_rs);

  always_comb begin
    // NOTE: every variable of a combinational block gets a default first; a
    // path that leaves one unassigned would infer a latch.
    jr_hazard = 1'b0;
    jr_value  = id_rs_val;
    if (rs_is_zero) begin
      jr_value = '0;
    end else if (hit_idex) begin
      jr_hazard = 1'b1;            // result not computed yet
    end else if (hit_exmem) begin
      if (exmem_load) begin
        jr_hazard = 1'b1;          // load data arrives one stage later
      end else begin
        jr_value = exmem_val;
      end
    end else if (hit_memwb) begin
      jr_value = memwb_val;
    end
  end

  assign jr_misaligned = (jr_value[1:0] != 2'b00);

  // The combinational stall is masked while reset is asserted, so every
  // output reads 0 as soon as reset goes low.
  assign stall = rst_n && dec_jr && jr_hazard && !flush;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // IDLE resolves any decoded jump. WAIT only exists for a pending jr. The
  // frozen IF/ID keeps that jr in place, so in WAIT only jr is resolved, and
  // anything else drops back to IDLE quietly. Target and link registers hold
  // their value between pulses, and are cleared by a flush.
  always_comb begin
    state_d         = ST_IDLE;
    redirect_d      = 1'b0;
    link_we_d       = 1'b0;
    misalign_d      = 1'b0;
    redirect_addr_d = redirect_addr_q;
    link_addr_d     = link_addr_q;

    if (flush) begin
      redirect_addr_d = '0;
      link_addr_d     = '0;
    end else if (dec_jr) begin
      if (jr_hazard) begin
        state_d = ST_WAIT;
      end else if (jr_misaligned) begin
        misalign_d = 1'b1;
      end else begin
        redirect_d      = 1'b1;
        redirect_addr_d = jr_value;
      end
    end else if ((state_q == ST_IDLE) && (dec_jal || dec_j)) begin
      redirect_d      = 1'b1;
      redirect_addr_d = jmp_target;
      if (dec_jal) begin
        link_we_d   = 1'b1;
        link_addr_d = id_pc4 + LINK_OFS;
      end
    end

    flush_if_d = (DELAY_SLOT == 0) && redirect_d;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      redirect_q      <= 1'b0;
      flush_if_q      <= 1'b0;
      link_we_q       <= 1'b0;
      misalign_q      <= 1'b0;
      redirect_addr_q <= '0;
      link_addr_q     <= '0;
    end else begin
      state_q         <= state_d;
      redirect_q      <= redirect_d;
      flush_if_q      <= flush_if_d;
      link_we_q       <= link_we_d;
      misalign_q      <= misalign_d;
      redirect_addr_q <= redirect_addr_d;
      link_addr_q     <= link_addr_d;
    end
  end

  assign redirect      = redirect_q;
  assign redirect_addr = redirect_addr_q;
  assign flush_if      = flush_if_q;
  assign link_we       = link_we_q;
  assign link_addr     = link_addr_q;
  assign misalign      = misalign_q;

endmodule

// File: tb/tb_jump_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_jump_resolve_unit
//
// This bench builds two instances of the unit from one shared stimulus:
//   dut_ds1 : DELAY_SLOT = 1
//   dut_ds0 : DELAY_SLOT = 0
//
// A cycle-level reference model predicts two things from the current inputs:
//   - the combinational stall, and
//   - the registered outputs after the next edge.
// It works from the jump rules directly, with a youngest-first scan over the
// pipeline producers.
//
// Directed test-plan scenarios come first. A randomized phase follows. While
// a stall is predicted, the random phase keeps the ID fields frozen, just as
// the IF/ID register would.
// -----------------------------------------------------------------------------
module tb_jump_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush, id_valid, id_j, id_jal, id_jr;
  logic [4:0]  id_rs;
  logic [31:0] id_rs_val;
  logic [25:0] id_imm;
  logic [31:0] id_pc4;
  logic [4:0]  idex_dst, exmem_dst, memwb_dst;
  logic        idex_wen, exmem_wen, exmem_load, memwb_wen;
  logic [31:0] exmem_val, memwb_val;

  logic        stall1, redirect1, flush_if1, link_we1, misalign1;
  logic [31:0] raddr1, laddr1;
  logic        stall0, redirect0, flush_if0, link_we0, misalign0;
  logic [31:0] raddr0, laddr0;

  typedef struct packed {
    logic        stall;
    logic        redirect;
    logic        flush_if;
    logic        link_we;
    logic        misalign;
    logic [31:0] raddr;
    logic [31:0] laddr;
  } obs_t;

  obs_t got1, got0, exp1, exp0, p1, p0;
  bit   pred_stall;
  logic last_stall1;
  int   n_checks = 0;
  int   n_pass   = 0;

  assign got1 = {stall1, redirect1, flush_if1, link_we1, misalign1, raddr1, laddr1};
  assign got0 = {stall0, redirect0, flush_if0, link_we0, misalign0, raddr0, laddr0};

  always #5 clk = ~clk;

  jump_resolve_unit #(.XLEN(32), .REGW(5), .IMMW(26), .DELAY_SLOT(1)) dut_ds1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
    .id_j(id_j), .id_jal(id_jal), .id_jr(id_jr), .id_rs(id_rs),
    .id_rs_val(id_rs_val), .id_imm(id_imm), .id_pc4(id_pc4),
    .idex_dst(idex_dst), .idex_wen(idex_wen),
    .exmem_dst(exmem_dst), .exmem_wen(exmem_wen), .exmem_load(exmem_load),
    .exmem_val(exmem_val), .memwb_dst(memwb_dst), .memwb_wen(memwb_wen),
    .memwb_val(memwb_val), .stall(stall1), .redirect(redirect1),
    .redirect_addr(raddr1), .flush_if(flush_if1), .link_we(link_we1),
    .link_addr(laddr1), .misalign(misalign1)
  );

  jump_resolve_unit #(.XLEN(32), .REGW(5), .IMMW(26), .DELAY_SLOT(0)) dut_ds0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
    .id_j(id_j), .id_jal(id_jal), .id_jr(id_jr), .id_rs(id_rs),
    .id_rs_val(id_rs_val), .id_imm(id_imm), .id_pc4(id_pc4),
    .idex_dst(idex_dst), .idex_wen(idex_wen),
    .exmem_dst(exmem_dst), .exmem_wen(exmem_wen), .exmem_load(exmem_load),
    .exmem_val(exmem_val), .memwb_dst(memwb_dst), .memwb_wen(memwb_wen),
    .memwb_val(memwb_val), .stall(stall0), .redirect(redirect0),
    .redirect_addr(raddr0), .flush_if(flush_if0), .link_we(link_we0),
    .link_addr(laddr0), .misalign(misalign0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reference model: stall of the current cycle, plus the registered outputs
  // after the coming edge.
  function automatic obs_t predict(input bit ds, input obs_t now);
    obs_t        nx;
    logic [4:0]  dsts [3];
    bit          wens [3];
    bit          busy [3];
    logic [31:0] vals [3];
    logic [31:0] val;
    bit          haz, found, live;
    nx          = now;
    nx.stall    = 1'b0;
    nx.redirect = 1'b0;
    nx.flush_if = 1'b0;
    nx.link_we  = 1'b0;
    nx.misalign = 1'b0;
    if (flush) begin
      nx.raddr = 32'h0;
      nx.laddr = 32'h0;
      return nx;
    end
    live = id_valid && !(!ds && now.redirect);
    if (!live) return nx;
    if (id_jr) begin
      dsts  = '{idex_dst, exmem_dst, memwb_dst};
      wens  = '{idex_wen, exmem_wen, memwb_wen};
      busy  = '{1'b1, exmem_load, 1'b0};
      vals  = '{32'h0, exmem_val, memwb_val};
      val   = id_rs_val;
      haz   = 1'b0;
      found = 1'b0;
      if (id_rs == 5'd0) val = 32'h0;
      else
        for (int k = 0; k < 3; k++)
          if (!found && wens[k] && dsts[k] == id_rs) begin
            found = 1'b1;
            haz   = busy[k];
            val   = vals[k];
          end
      if (haz) nx.stall = 1'b1;
      else if (val % 4 != 0) nx.misalign = 1'b1;
      else begin
        nx.redirect = 1'b1;
        nx.raddr    = val;
      end
    end else if (id_jal || id_j) begin
      nx.redirect = 1'b1;
      nx.raddr    = (id_pc4 & 32'hF000_0000) | (32'(id_imm) * 4);
      if (id_jal) begin
        nx.link_we = 1'b1;
        nx.laddr   = id_pc4 + (ds ? 32'd4 : 32'd0);
      end
    end
    nx.flush_if = !ds && nx.redirect;
    return nx;
  endfunction

  task automatic compare_regs(input string who, input obs_t got, input obs_t exp);
    check({who, ".redirect"},      32'(got.redirect), 32'(exp.redirect));
    check({who, ".flush_if"},      32'(got.flush_if), 32'(exp.flush_if));
    check({who, ".link_we"},       32'(got.link_we),  32'(exp.link_we));
    check({who, ".misalign"},      32'(got.misalign), 32'(exp.misalign));
    check({who, ".redirect_addr"}, got.raddr,         exp.raddr);
    check({who, ".link_addr"},     got.laddr,         exp.laddr);
  endtask

  // Called just after inputs are driven on a falling edge.
  task automatic step();
    #1;
    p1 = predict(1'b1, exp1);
    p0 = predict(1'b0, exp0);
    last_stall1 = stall1;
    check("ds1.stall", 32'(stall1), 32'(p1.stall));
    check("ds0.stall", 32'(stall0), 32'(p0.stall));
    pred_stall = p1.stall || p0.stall;
    @(posedge clk);
    #1;
    exp1 = p1;
    exp0 = p0;
    compare_regs("ds1", got1, exp1);
    compare_regs("ds0", got0, exp0);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    flush = 0; id_valid = 0; id_j = 0; id_jal = 0; id_jr = 0;
    id_rs = 0; id_rs_val = 0; id_imm = 0; id_pc4 = 0;
    idex_dst = 0; idex_wen = 0; exmem_dst = 0; exmem_wen = 0; exmem_load = 0;
    exmem_val = 0; memwb_dst = 0; memwb_wen = 0; memwb_val = 0;
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) != 0) v[1:0] = 2'b00;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    pred_stall = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset.ds1.stall", 32'(stall1), 32'h0);
    compare_regs("reset.ds1", got1, '0);
    compare_regs("reset.ds0", got0, '0);
    exp1 = '0;
    exp0 = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // j: region 0 of PC+4 with immediate 0x100 -> 0x400
    id_valid = 1; id_j = 1; id_pc4 = 32'h0040_0010; id_imm = 26'h100;
    step();
    check("tp_j.stall", 32'(last_stall1), 32'h0);
    check("tp_j.redirect", 32'(redirect1), 32'h1);
    check("tp_j.addr", raddr1, 32'h0000_0400);
    clear_inputs();
    step();
    check("tp_j.pulse_end", 32'(redirect1), 32'h0);

    // jal, then a j in the following cycle (squashed only without delay slot)
    id_valid = 1; id_jal = 1; id_pc4 = 32'h0040_0020; id_imm = 26'h40;
    step();
    check("tp_jal.link_we", 32'(link_we1), 32'h1);
    check("tp_jal.ds1.link", laddr1, 32'h0040_0024);
    check("tp_jal.ds0.link", laddr0, 32'h0040_0020);
    check("tp_jal.ds0.flush_if", 32'(flush_if0), 32'h1);
    check("tp_jal.ds1.flush_if", 32'(flush_if1), 32'h0);
    id_jal = 0; id_j = 1; id_imm = 26'h200;
    step();
    check("squash.ds1.redirect", 32'(redirect1), 32'h1);
    check("squash.ds0.redirect", 32'(redirect0), 32'h0);
    clear_inputs();
    step();

    // jr waits on an ALU producer, then on a load, then forwards from MEM/WB
    id_valid = 1; id_jr = 1; id_rs = 8; id_rs_val = 32'hDEAD_0000;
    idex_dst = 8; idex_wen = 1;
    step();
    check("tp_jr.stall1", 32'(last_stall1), 32'h1);
    idex_wen = 0; exmem_dst = 8; exmem_wen = 1; exmem_load = 1;
    step();
    check("tp_jr.stall2", 32'(last_stall1), 32'h1);
    exmem_wen = 0; exmem_load = 0; memwb_dst = 8; memwb_wen = 1; memwb_val = 32'h0040_1000;
    step();
    check("tp_jr.stall3", 32'(last_stall1), 32'h0);
    check("tp_jr.redirect", 32'(redirect1), 32'h1);
    check("tp_jr.addr", raddr1, 32'h0040_1000);
    clear_inputs();
    step();

    // EX/MEM beats MEM/WB
    id_valid = 1; id_jr = 1; id_rs = 9;
    exmem_dst = 9; exmem_wen = 1; exmem_val = 32'h100;
    memwb_dst = 9; memwb_wen = 1; memwb_val = 32'h200;
    step();
    check("tp_fwd.addr", raddr1, 32'h100);
    // rs = 0 with an ID/EX writer of $0: no stall, target 0
    clear_inputs();
    id_valid = 1; id_jr = 1; id_rs = 0; id_rs_val = 32'h1234; idex_dst = 0; idex_wen = 1;
    step();
    check("tp_r0.stall", 32'(last_stall1), 32'h0);
    check("tp_r0.redirect", 32'(redirect1), 32'h1);
    check("tp_r0.addr", raddr1, 32'h0);

    // misaligned forwarded target
    clear_inputs();
    id_valid = 1; id_jr = 1; id_rs = 5; exmem_dst = 5; exmem_wen = 1; exmem_val = 32'h0040_0002;
    step();
    check("tp_mis.misalign", 32'(misalign1), 32'h1);
    check("tp_mis.redirect", 32'(redirect1), 32'h0);

    // flush while waiting
    clear_inputs();
    id_valid = 1; id_jr = 1; id_rs = 6; idex_dst = 6; idex_wen = 1;
    step();
    flush = 1;
    step();
    check("tp_flush.stall", 32'(last_stall1), 32'h0);
    clear_inputs();
    step();
    check("tp_flush.redirect", 32'(redirect1), 32'h0);

    // j and jr together: jr wins
    id_valid = 1; id_j = 1; id_jr = 1; id_rs = 3; id_rs_val = 32'h1000; id_imm = 26'h777;
    step();
    check("tp_prio.addr", raddr1, 32'h1000);

    // reset while waiting
    clear_inputs();
    id_valid = 1; id_jr = 1; id_rs = 4; idex_dst = 4; idex_wen = 1;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_wait.stall", 32'(stall1), 32'h0);
    compare_regs("rst_wait.ds1", got1, '0);
    @(posedge clk);
    #1;
    check("rst_wait.redirect", 32'(redirect1), 32'h0);
    exp1 = '0;
    exp0 = '0;
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    step();

    // randomized phase
    for (int i = 0; i < 400; i++) begin
      if (!pred_stall) begin
        id_valid  = ($urandom_range(0, 9) < 8);
        id_j      = 1'($urandom_range(0, 1));
        id_jal    = 1'($urandom_range(0, 1));
        id_jr     = 1'($urandom_range(0, 1));
        id_rs     = 5'($urandom_range(0, 3));
        id_rs_val = rand_val();
        id_imm    = 26'($urandom);
        id_pc4    = $urandom;
      end
      idex_dst   = 5'($urandom_range(0, 3));
      idex_wen   = ($urandom_range(0, 2) == 0);
      exmem_dst  = 5'($urandom_range(0, 3));
      exmem_wen  = 1'($urandom_range(0, 1));
      exmem_load = ($urandom_range(0, 2) == 0);
      exmem_val  = rand_val();
      memwb_dst  = 5'($urandom_range(0, 3));
      memwb_wen  = 1'($urandom_range(0, 1));
      memwb_val  = rand_val();
      flush      = ($urandom_range(0, 99) < 8);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jump_resolve_unit.md
Name: jump_resolve_unit

Overview:
Parametrised jump-target resolution stage for the pipelined MIPS core. It sits in ID and resolves j, jal and jr targets. For jr it forwards rs from EX/MEM or MEM/WB, and stalls via a small FSM when rs is not yet available. It issues a registered one-cycle redirect pulse to IF, plus the link value for jal. Optional branch-delay-slot mode.

Parameters:
XLEN, 32, datapath/address width
REGW, 5, register index width
IMMW, 26, jump immediate width (XLEN >= IMMW+3)
DELAY_SLOT, 1, 1 = architectural delay slot (no IF flush); 0 = flush_if on redirect

Ports:
clk  in  1  core clock
rst_n  in  1  async active-low reset
flush  in  1  squash from later stage; cancels pending work
id_valid  in  1  ID holds a valid instruction
id_j  in  1  decoded j
id_jal  in  1  decoded jal
id_jr  in  1  decoded jr
id_rs  in  REGW  rs index
id_rs_val  in  XLEN  register-file rs value
id_imm  in  IMMW  jump immediate
id_pc4  in  XLEN  PC+4 of ID instruction
idex_dst  in  REGW  ID/EX destination
idex_wen  in  1  ID/EX writes register
exmem_dst  in  REGW  EX/MEM destination
exmem_wen  in  1  EX/MEM writes register
exmem_load  in  1  EX/MEM is a load (data not ready)
exmem_val  in  XLEN  EX/MEM ALU result
memwb_dst  in  REGW  MEM/WB destination
memwb_wen  in  1  MEM/WB writes register
memwb_val  in  XLEN  MEM/WB writeback value
stall  out  1  freeze PC and IF/ID (combinational)
redirect  out  1  one-cycle redirect pulse (registered)
redirect_addr  out  XLEN  target (registered)
flush_if  out  1  squash IF instruction (registered; always 0 if DELAY_SLOT=1)
link_we  out  1  write link to $31 (registered pulse)
link_addr  out  XLEN  return address (registered)
misalign  out  1  jr target low 2 bits nonzero (registered pulse)

Behaviour:
- Reset (rst_n=0, async): state=IDLE; all registered outputs 0.
- Decode priority: id_jr > id_jal > id_j. The instruction is a jump when id_valid and any of the three is set.
- j/jal target: {id_pc4[XLEN-1:IMMW+2], id_imm, 2'b00}. Never stalls.
- jr operand, first match wins:
  1. id_rs==0 -> value 0.
  2. idex_wen and idex_dst==id_rs -> hazard.
  3. exmem_wen and exmem_dst==id_rs -> hazard if exmem_load, else exmem_val.
  4. memwb_wen and memwb_dst==id_rs -> memwb_val.
  5. Otherwise id_rs_val.
- Destination register 0 never matches, so it never causes forwarding or a hazard.
- stall = jr and hazard and !flush, evaluated combinationally every cycle.
- FSM:
  - IDLE: on a resolvable jump, register outputs at the next edge and stay in IDLE. On a jr hazard, go to WAIT.
  - WAIT: stall=1. Inputs are held stable by the frozen IF/ID. Re-evaluate each cycle; when the hazard clears, issue the redirect and return to IDLE. Worst case is 2 WAIT cycles (ALU producer in ID/EX, then a load in EX/MEM).
- Latency: redirect asserts exactly 1 cycle after the resolving ID cycle and is high for exactly 1 cycle.
- jal: link_we=1 and link_addr=id_pc4+(DELAY_SLOT?4:0), in the same cycle as redirect.
- flush_if = redirect when DELAY_SLOT=0.
- Squash window (DELAY_SLOT=0): in the cycle redirect=1, id_valid is ignored, because that instruction is being flushed.
- Misaligned jr target (low bits !=0): no redirect is issued; misalign pulses 1 cycle instead.
- flush=1 in any state:
  - state -> IDLE.
  - Registered outputs load 0 on that edge; a pulse already high completes its cycle.
  - The current ID instruction is not resolved.
- flush and a new jump in the same cycle: flush wins.
- Reset mid-WAIT: immediate IDLE, no redirect.

Test Plan:
- j with id_pc4=0x0040_0010, id_imm=0x0000100 -> next cycle redirect=1, redirect_addr=0x0000_0400, stall never 1.
- jal, id_pc4=0x0040_0020, DELAY_SLOT=1 -> redirect, link_we=1, link_addr=0x0040_0024. With DELAY_SLOT=0 -> link_addr=0x0040_0020 and flush_if=1.
- jr rs=8, idex_dst=8, idex_wen=1, then the producer moves to EX/MEM as a load, then to MEM/WB with memwb_val=0x0040_1000 -> stall=1 for 2 cycles, then redirect_addr=0x0040_1000.
- jr rs=9, exmem_dst=9 non-load with exmem_val=0x100, and memwb_dst=9 with memwb_val=0x200 -> redirect_addr=0x100 (EX/MEM wins). Also rs=0 with idex_dst=0, idex_wen=1 -> no stall, target 0.
- jr forwarded value 0x0040_0002 -> misalign=1 and no redirect. Separately, flush asserted in WAIT -> stall drops the same cycle, no redirect.
- id_j and id_jr both set, rs value 0x1000 -> target 0x1000. Separately, rst_n low mid-WAIT -> all outputs 0 immediately.
